// File: rtl/mips32_pkg.sv
// mips32_pkg: definitions shared by the MIPS32 pipeline blocks.
//   - instruction opcode constants and instruction type codes
//   - requester IDs for the unified memory arbiter
//   - arbiter FSM state encoding
//   - a helper that flags word addresses outside the memory
package mips32_pkg;

    // Opcodes
    localparam logic [5:0] ADD   = 6'b000000;
    localparam logic [5:0] SUB   = 6'b000001;
    localparam logic [5:0] AND   = 6'b000010;
    localparam logic [5:0] OR    = 6'b000011;
    localparam logic [5:0] SLT   = 6'b000100;
    localparam logic [5:0] MUL   = 6'b000101;
    localparam logic [5:0] HLT   = 6'b111111;
    localparam logic [5:0] LW    = 6'b001000;
    localparam logic [5:0] SW    = 6'b001001;
    localparam logic [5:0] ADDI  = 6'b001010;
    localparam logic [5:0] SUBI  = 6'b001011;
    localparam logic [5:0] SLTI  = 6'b001100;
    localparam logic [5:0] BNEQZ = 6'b001101;
    localparam logic [5:0] BEQZ  = 6'b001110;

    // Instruction type codes
    localparam logic [2:0] RR_ALU = 3'b000;
    localparam logic [2:0] RM_ALU = 3'b001;
    localparam logic [2:0] LOAD   = 3'b010;
    localparam logic [2:0] STORE  = 3'b011;
    localparam logic [2:0] BRANCH = 3'b100;
    localparam logic [2:0] HALT   = 3'b101;

    // Memory requester IDs
    typedef logic [1:0] req_id_t;
    localparam req_id_t REQ_IF   = 2'd0;
    localparam req_id_t REQ_DM   = 2'd1;
    localparam req_id_t REQ_LD   = 2'd2;
    localparam req_id_t REQ_NONE = 2'd3;

    // Arbiter FSM: IDLE accepts requests, RD_WAIT covers the extra read latency cycles
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } arb_state_t;

    // A word address is out of range when any bit above the memory address width is set
    function automatic logic addr_out_of_range(input logic [31:0] addr, input int aw);
        return (addr >> aw) != 32'h0;
    endfunction

endpackage

// File: rtl/mips32_mem_arbiter_if.sv
// mips32_mem_arbiter_if: bundle of the requester buses and the memory macro bus
// around the unified-memory arbiter.
//   slave  : the arbiter side (takes requests and mem_rdata, drives grants/returns/memory strobes)
//   master : the pipeline + memory side (drives requests and mem_rdata)
//
// Handshake: a requester raises *_req with addr/we/wdata and holds all of them
// stable until it sees *_gnt high; *_gnt is high in the accepting cycle only and
// may depend combinationally on the requests of that cycle. A granted read returns
// exactly one *_rvalid pulse (rdata valid in that cycle) RD_LAT cycles later; a
// granted write returns nothing.
interface mips32_mem_arbiter_if #(
    parameter int AW = 10
);
    logic          halted;

    logic          if_req;
    logic [31:0]   if_addr;
    logic          if_gnt;
    logic          if_rvalid;

    logic          dm_req;
    logic          dm_we;
    logic [31:0]   dm_addr;
    logic [31:0]   dm_wdata;
    logic          dm_gnt;
    logic          dm_rvalid;

    logic          ld_req;
    logic          ld_we;
    logic [31:0]   ld_addr;
    logic [31:0]   ld_wdata;
    logic          ld_gnt;
    logic          ld_rvalid;

    logic [31:0]   rdata;
    logic          err;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport slave (
        input  halted,
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        input  ld_req, ld_we, ld_addr, ld_wdata,
        input  mem_rdata,
        output if_gnt, if_rvalid,
        output dm_gnt, dm_rvalid,
        output ld_gnt, ld_rvalid,
        output rdata, err,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output halted,
        output if_req, if_addr,
        output dm_req, dm_we, dm_addr, dm_wdata,
        output ld_req, ld_we, ld_addr, ld_wdata,
        output mem_rdata,
        input  if_gnt, if_rvalid,
        input  dm_gnt, dm_rvalid,
        input  ld_gnt, ld_rvalid,
        input  rdata, err,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mips32_prio_pick.sv
// mips32_prio_pick: combinational 3-way fixed-priority picker.
//   req_if, req_dm, req_ld : already-masked requests (zero when they may not win)
//   starve                 : promote IF above DM for this pick
//   winner                 : REQ_IF / REQ_DM / REQ_LD, or REQ_NONE when nothing requests
module mips32_prio_pick
    import mips32_pkg::*;
(
    input  logic    req_if,
    input  logic    req_dm,
    input  logic    req_ld,
    input  logic    starve,
    output req_id_t winner
);

    always_comb begin
        winner = REQ_NONE;
        if (req_ld) begin
            winner = REQ_LD;
        end else if (starve && req_if) begin
            winner = REQ_IF;
        end else if (req_dm) begin
            winner = REQ_DM;
        end else if (req_if) begin
            winner = REQ_IF;
        end
    end

endmodule

// File: rtl/mips32_mem_arbiter.sv
// mips32_mem_arbiter: shares the single-ported unified memory between
// instruction fetch (IF), load/store (DM) and the loader/debug port (LD).
//   clk, rst   : clock and asynchronous active-high reset
//   bus        : requester buses, read return bus, err pulse and memory macro bus
//   state      : current FSM state (observation)
//   starve_cnt : consecutive lost IF arbitrations (observation)
// Priority is LD > DM > IF, with IF promoted above DM once it has lost
// STARVE_MAX arbitrations in a row. A halted pipeline cannot fetch.
module mips32_mem_arbiter
    import mips32_pkg::*;
#(
    parameter  int DEPTH      = 1024,
    parameter  int AW         = $clog2(DEPTH),
    parameter  int RD_LAT     = 1,
    parameter  int STARVE_MAX = 4,
    localparam int SW         = $clog2(STARVE_MAX + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    mips32_mem_arbiter_if.slave     bus,
    output arb_state_t              state,
    output logic [SW-1:0]           starve_cnt
);

    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
    localparam logic [1:0]    LAT_LOAD   = 2'(RD_LAT - 1);

    logic [1:0]  lat_cnt;
    req_id_t     owner;
    logic        resp_valid;   // this cycle is the read response cycle of `owner`
    logic        resp_oor;     // that read was out of range: return zero
    logic        err_r;

    logic        arb_en;
    logic        if_live;
    req_id_t     winner;
    logic        granted;
    logic [31:0] sel_addr;
    logic        sel_we;
    logic [31:0] sel_wdata;
    logic        sel_oor;

    // Grants only happen in IDLE and never while reset is asserted.
    assign arb_en  = (state == ST_IDLE) && !rst;
    assign if_live = bus.if_req && !bus.halted;

    mips32_prio_pick u_pick (
        .req_if (if_live    && arb_en),
        .req_dm (bus.dm_req && arb_en),
        .req_ld (bus.ld_req && arb_en),
        .starve (starve_cnt == STARVE_TOP),
        .winner (winner)
    );

    always_comb begin
        sel_addr  = 32'h0;
        sel_we    = 1'b0;
        sel_wdata = 32'h0;
        case (winner)
            REQ_IF: begin
                sel_addr = bus.if_addr;
            end
            REQ_DM: begin
                sel_addr  = bus.dm_addr;
                sel_we    = bus.dm_we;
                sel_wdata = bus.dm_wdata;
            end
            REQ_LD: begin
                sel_addr  = bus.ld_addr;
                sel_we    = bus.ld_we;
                sel_wdata = bus.ld_wdata;
            end
            default: ;
        endcase
    end

    assign granted = (winner != REQ_NONE);
    assign sel_oor = granted && addr_out_of_range(sel_addr, AW);

    assign bus.if_gnt = (winner == REQ_IF);
    assign bus.dm_gnt = (winner == REQ_DM);
    assign bus.ld_gnt = (winner == REQ_LD);

    // Out-of-range accesses are accepted but never reach the memory.
    assign bus.mem_en    = granted && !sel_oor;
    assign bus.mem_we    = bus.mem_en && sel_we;
    assign bus.mem_addr  = sel_addr[AW-1:0];
    assign bus.mem_wdata = sel_we ? sel_wdata : 32'h0;

    assign bus.if_rvalid = resp_valid && (owner == REQ_IF);
    assign bus.dm_rvalid = resp_valid && (owner == REQ_DM);
    assign bus.ld_rvalid = resp_valid && (owner == REQ_LD);
    assign bus.rdata     = (resp_valid && !resp_oor) ? bus.mem_rdata : 32'h0;
    assign bus.err       = err_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            lat_cnt    <= 2'd0;
            owner      <= REQ_NONE;
            starve_cnt <= '0;
            resp_valid <= 1'b0;
            resp_oor   <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            err_r <= sel_oor;
            case (state)
                ST_IDLE: begin
                    // Default: the current response (if any) ends this cycle.
                    resp_valid <= 1'b0;
                    resp_oor   <= 1'b0;
                    owner      <= REQ_NONE;
                    if (granted && !sel_we) begin
                        owner    <= winner;
                        resp_oor <= sel_oor;
                        if (RD_LAT == 1) begin
                            resp_valid <= 1'b1;
                        end else begin
                            state   <= ST_RD_WAIT;
                            lat_cnt <= LAT_LOAD;
                        end
                    end
                    // Count only arbitrations an unmasked fetch actually lost.
                    if (winner == REQ_IF) begin
                        starve_cnt <= '0;
                    end else if (if_live && (starve_cnt != STARVE_TOP)) begin
                        starve_cnt <= starve_cnt + 1'b1;
                    end
                end
                ST_RD_WAIT: begin
                    // Leave on the last wait cycle so the response cycle is IDLE.
                    lat_cnt <= lat_cnt - 2'd1;
                    if (lat_cnt == 2'd1) begin
                        state      <= ST_IDLE;
                        resp_valid <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
module tb_mips32_mem_arbiter;
    import mips32_pkg::*;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int L     = 2;
    localparam int SMAX  = 4;
    localparam int SW    = $clog2(SMAX + 1);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mips32_mem_arbiter_if #(.AW(AW)) bus();
    arb_state_t    state;
    logic [SW-1:0] starve_cnt;

    mips32_mem_arbiter #(
        .DEPTH(DEPTH), .AW(AW), .RD_LAT(L), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .state(state), .starve_cnt(starve_cnt)
    );

    // ---------------- memory macro model ----------------
    logic [31:0] mem     [DEPTH];
    logic [31:0] rd_pipe [L];
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        rd_pipe[0] <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr] : 32'hBAD0_BAD0;
        for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.mem_rdata = rd_pipe[L-1];

    // ---------------- scoreboard state ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    logic [65:0] exp_q[$];   // {due cycle, requester, data}
    int          err_q[$];   // cycles in which err must pulse

    // reference model: memory contents, blocked cycles, lost-fetch count
    logic [31:0] m_mem [DEPTH];
    int m_wait   = 0;
    int m_starve = 0;

    // requester driver state
    logic        p_if = 0, p_dm = 0, p_ld = 0;
    logic        dm_w = 0, ld_w = 0;
    logic [31:0] if_a = 0, dm_a = 0, ld_a = 0, dm_d = 0, ld_d = 0;
    logic        halt_v = 0;
    int rate_if = 0, rate_dm = 0, rate_ld = 0, rate_oor = 0, rate_halt = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] gen_addr();
        if ($urandom_range(99) < rate_oor) return 32'h0000_0400 + $urandom_range(0, 4095);
        return 32'($urandom_range(0, 15));
    endfunction

    task automatic drive();
        bus.halted   = halt_v;
        bus.if_req   = p_if;
        bus.if_addr  = p_if ? if_a : 32'h0;
        bus.dm_req   = p_dm;
        bus.dm_we    = p_dm ? dm_w : 1'b0;
        bus.dm_addr  = p_dm ? dm_a : 32'h0;
        bus.dm_wdata = p_dm ? dm_d : 32'h0;
        bus.ld_req   = p_ld;
        bus.ld_we    = p_ld ? ld_w : 1'b0;
        bus.ld_addr  = p_ld ? ld_a : 32'h0;
        bus.ld_wdata = p_ld ? ld_d : 32'h0;
    endtask

    // One clock cycle: drive, compare grant/memory strobes with the model, advance the model.
    task automatic step();
        int          win;
        logic [31:0] a, d;
        logic        w, oor, live;
        logic [2:0]  exp_g;
        @(posedge clk); #1;
        drive();
        @(negedge clk);
        live = p_if && !halt_v;
        win  = 3;
        if (m_wait == 0) begin
            if (p_ld)                        win = 2;
            else if (live && m_starve == SMAX) win = 0;
            else if (p_dm)                   win = 1;
            else if (live)                   win = 0;
        end
        exp_g = (win == 3) ? 3'b000 : 3'(1 << win);
        check("gnt", {bus.ld_gnt, bus.dm_gnt, bus.if_gnt}, exp_g);
        check("starve_cnt", starve_cnt, m_starve);
        check("rd_wait_state", state == ST_RD_WAIT, m_wait > 0);
        a = 0; d = 0; w = 0;
        case (win)
            0: a = if_a;
            1: begin a = dm_a; w = dm_w; d = dm_d; end
            2: begin a = ld_a; w = ld_w; d = ld_d; end
            default: ;
        endcase
        oor = (win != 3) && (a >= DEPTH);
        check("mem_en", bus.mem_en, (win != 3) && !oor);
        check("mem_we", bus.mem_we, (win != 3) && !oor && w);
        if ((win != 3) && !oor) check("mem_addr", bus.mem_addr, a % DEPTH);
        if ((win != 3) && !oor && w) check("mem_wdata", bus.mem_wdata, d);
        if (win != 3) begin
            if (oor) err_q.push_back(cyc + 1);
            if (w) begin
                if (!oor) m_mem[a % DEPTH] = d;
            end else begin
                exp_q.push_back({32'(cyc + L), 2'(win), oor ? 32'h0 : m_mem[a % DEPTH]});
                m_wait = L - 1;
            end
            if (win == 0) m_starve = 0;
            else if (live && m_starve < SMAX) m_starve++;
            case (win)
                0: p_if = 0;
                1: p_dm = 0;
                default: p_ld = 0;
            endcase
        end else if (m_wait > 0) begin
            m_wait--;
        end
        // new random traffic for idle requesters
        if (!p_ld && $urandom_range(99) < rate_ld) begin
            p_ld = 1; ld_w = 1'($urandom_range(0, 1)); ld_a = gen_addr(); ld_d = $urandom;
        end
        if (!p_dm && $urandom_range(99) < rate_dm) begin
            p_dm = 1; dm_w = 1'($urandom_range(0, 1)); dm_a = gen_addr(); dm_d = $urandom;
        end
        if (!p_if && $urandom_range(99) < rate_if) begin
            p_if = 1; if_a = gen_addr();
        end
        if ($urandom_range(99) < rate_halt) halt_v = !halt_v;
    endtask

    task automatic check_quiet_outputs(input string tag);
        check({tag, "_gnts"},    {bus.ld_gnt, bus.dm_gnt, bus.if_gnt}, 3'b000);
        check({tag, "_rvalids"}, {bus.ld_rvalid, bus.dm_rvalid, bus.if_rvalid}, 3'b000);
        check({tag, "_mem_en"},  {bus.mem_en, bus.mem_we}, 2'b00);
        check({tag, "_mem_bus"}, {bus.mem_addr, bus.mem_wdata}, 64'h0);
        check({tag, "_rdata"},   bus.rdata, 32'h0);
        check({tag, "_err"},     bus.err, 1'b0);
        check({tag, "_state"},   state == ST_IDLE, 1'b1);
        check({tag, "_starve"},  starve_cnt, 0);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1;
        p_if = 0; p_dm = 0; p_ld = 0; halt_v = 0;
        drive();
        exp_q.delete(); err_q.delete();
        m_wait = 0; m_starve = 0;
        @(negedge clk);
        check_quiet_outputs("in_reset");
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check_quiet_outputs("after_reset");
    endtask

    // ---------------- monitor: read returns and err pulses ----------------
    initial begin
        logic [65:0] e;
        logic [2:0]  exp_v;
        logic [31:0] exp_d;
        logic        exp_e;
        forever begin
            @(negedge clk);
            exp_v = 0; exp_d = 0; exp_e = 0;
            if (!rst) begin
                while (exp_q.size() > 0 && int'(exp_q[0][65:34]) < cyc) begin
                    e = exp_q.pop_front();
                    n_cmp++; n_fail++;
                    $display("FAIL rvalid_missing @cyc %0d: got=none expected=req%0d data %0h", cyc, e[33:32], e[31:0]);
                end
                if (exp_q.size() > 0 && int'(exp_q[0][65:34]) == cyc) begin
                    e = exp_q.pop_front();
                    exp_v = 3'(1 << e[33:32]);
                    exp_d = e[31:0];
                end
                if (err_q.size() > 0 && err_q[0] == cyc) begin
                    void'(err_q.pop_front());
                    exp_e = 1;
                end
            end
            check("rvalid", {bus.ld_rvalid, bus.dm_rvalid, bus.if_rvalid}, exp_v);
            if (exp_v != 0) check("rdata", bus.rdata, exp_d);
            check("err", bus.err, exp_e);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int saved;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]   = 32'(i) * 32'h0101_0101 ^ 32'h5A5A_0000;
            m_mem[i] = 32'(i) * 32'h0101_0101 ^ 32'h5A5A_0000;
        end
        drive();
        // reset with requests present: nothing may be granted
        bus.ld_req = 1; bus.dm_req = 1; bus.if_req = 1;
        repeat (2) @(negedge clk);
        check_quiet_outputs("por");
        drive();
        @(posedge clk); #1 rst = 0;
        step();

        // loader write then read-back of address 5
        p_ld = 1; ld_w = 1; ld_a = 5; ld_d = 32'hDEAD_BEEF;
        step();
        p_ld = 1; ld_w = 0; ld_a = 5;
        repeat (L + 2) step();

        // fetch and data read in the same cycle
        p_if = 1; if_a = 7; p_dm = 1; dm_w = 0; dm_a = 8;
        repeat (2 * L + 2) step();

        // continuous stores starve fetch until promotion
        p_if = 1; if_a = 9;
        for (int i = 0; i < 12; i++) begin
            if (!p_dm) begin p_dm = 1; dm_w = 1; dm_a = 32'(i % 16); dm_d = $urandom; end
            step();
        end
        p_dm = 0;
        repeat (L + 1) step();

        // out-of-range data read
        p_dm = 1; dm_w = 0; dm_a = 32'h0000_0400;
        repeat (L + 2) step();

        // halted masks fetch and freezes the lost-arbitration count
        p_if = 1; if_a = 3;
        for (int i = 0; i < 2; i++) begin
            p_dm = 1; dm_w = 1; dm_a = 1; dm_d = $urandom;
            step();
        end
        halt_v = 1;
        saved = m_starve;
        for (int i = 0; i < 10; i++) begin
            if (!p_dm) begin p_dm = 1; dm_w = 1; dm_a = 2; dm_d = $urandom; end
            step();
        end
        check("halt_starve_hold", starve_cnt, saved);
        check("halt_if_pending", p_if, 1'b1);
        p_dm = 0;
        repeat (L) step();
        halt_v = 0;
        repeat (L + 2) step();

        // random mixed traffic
        rate_if = 40; rate_dm = 40; rate_ld = 15; rate_oor = 5; rate_halt = 3;
        repeat (800) step();
        rate_if = 0; rate_dm = 0; rate_ld = 0; rate_halt = 0;
        halt_v = 0;
        repeat (3 * L + 4) step();
        p_if = 0; p_dm = 0; p_ld = 0;

        // reset in the middle of a data read: its response must never appear
        p_dm = 1; dm_w = 0; dm_a = 4;
        step();
        apply_reset();
        repeat (L + 3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
